// File: rtl/resp_pkg.sv
// Shared definitions for the response signature compactor: FSM states and
// the default MISR polynomial and seed.
package resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/resp_sig_compactor_misr_step.sv
// One MISR step: shift left, fold the outgoing MSB back through the polynomial,
// then XOR in the response vector.
module misr_step #(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] POLY   = resp_pkg::CRC32_POLY
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] nxt
);

    logic [DATA_W-1:0] fb;

    assign fb  = cur[DATA_W-1] ? POLY : '0;
    assign nxt = {cur[DATA_W-2:0], 1'b0} ^ fb ^ data;

endmodule

// File: rtl/resp_sig_compactor.sv
// Compacts a stream of response vectors into a MISR signature and compares it
// against an expected value once the programmed number of vectors is in.
module resp_sig_compactor
    import resp_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] POLY   = CRC32_POLY,
    parameter logic [DATA_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [DATA_W-1:0] exp_sig,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] signature,
    output logic [CNT_W-1:0]  vec_cnt
);

    state_t            state;
    logic [DATA_W-1:0] misr;
    logic [DATA_W-1:0] misr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  num_vec_r;
    logic [DATA_W-1:0] exp_sig_r;
    logic              pass_r;

    misr_step #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_misr_step (
        .cur  (misr),
        .data (in_data),
        .nxt  (misr_nxt)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            misr      <= SEED;
            cnt       <= '0;
            num_vec_r <= '0;
            exp_sig_r <= '0;
            pass_r    <= 1'b0;
        end else if (clear) begin
            // Abort keeps the partial signature and count visible for debug.
            state  <= IDLE;
            pass_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        misr      <= SEED;
                        cnt       <= '0;
                        num_vec_r <= num_vec;
                        exp_sig_r <= exp_sig;
                        if (num_vec == '0) begin
                            state  <= DONE;
                            pass_r <= (SEED == exp_sig);
                        end else begin
                            state  <= RUN;
                            pass_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        misr <= misr_nxt;
                        cnt  <= cnt_inc;
                        // Final vector: compare against the signature it produces.
                        if (cnt_inc == num_vec_r) begin
                            state  <= DONE;
                            pass_r <= (misr_nxt == exp_sig_r);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = pass_r;
    assign signature = misr;
    assign vec_cnt   = cnt;

endmodule

// File: tb/tb_resp_sig_compactor.sv
// Bench for resp_sig_compactor: a SEED=0 and a default-SEED instance share one
// stimulus stream; finished runs are checked against a queue of expected results.
module tb_resp_sig_compactor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = '0;
    logic [31:0] exp_sig = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy0, busy0, done0, pass0;
    logic [31:0] sig0;
    logic [15:0] cnt0;
    logic        rdy1, busy1, done1, pass1;
    logic [31:0] sig1;
    logic [15:0] cnt1;

    always #5 clk = ~clk;

    resp_sig_compactor #(.SEED(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .num_vec(num_vec), .exp_sig(exp_sig), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .busy(busy0), .done(done0), .pass(pass0),
        .signature(sig0), .vec_cnt(cnt0)
    );

    resp_sig_compactor dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .num_vec(num_vec), .exp_sig(exp_sig), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .vec_cnt(cnt1)
    );

    typedef struct {
        logic [31:0] sig0;
        logic [31:0] sig1;
        logic        pass0;
        logic        pass1;
        int          cnt;
    } exp_t;

    typedef struct {
        logic [15:0] nv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] es;
        logic [31:0] e_sig0;
        logic [31:0] e_sig1;
        logic        e_pass0;
        logic        e_pass1;
        logic [15:0] e_cnt;
    } vec_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    logic [31:0] m0, m1, mes;
    int          mnv, mcnt;
    bit          mrun = 1'b0;
    logic        done_prev = 1'b0;

    function automatic logic [31:0] ref_step(logic [31:0] c, logic [31:0] d);
        logic [31:0] r;
        r = {c[30:0], 1'b0};
        if (c[31]) r = r ^ 32'h04C11DB7;
        return r ^ d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.sig0  = m0;
        e.sig1  = m1;
        e.pass0 = (m0 == mes);
        e.pass1 = (m1 == mes);
        e.cnt   = mcnt;
        sb.push_back(e);
    endtask

    task automatic start_run(input logic [15:0] nv, input logic [31:0] es);
        num_vec = nv;
        exp_sig = es;
        start   = 1'b1;
        if (!mrun) begin
            mnv  = int'(nv);
            mes  = es;
            m0   = 32'h0;
            m1   = 32'hFFFFFFFF;
            mcnt = 0;
            if (nv == 16'd0) push_exp();
            else mrun = 1'b1;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mrun  = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!rdy0 && guard < 50) begin
            tick();
            guard++;
        end
        if (!rdy0) begin
            chk("beat_ready_timeout", {31'h0, rdy0}, 32'h1);
        end else begin
            m0 = ref_step(m0, d);
            m1 = ref_step(m1, d);
            mcnt++;
            if (mcnt == mnv) begin
                push_exp();
                mrun = 1'b0;
            end
        end
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_done(input string nm);
        int guard;
        guard = 0;
        while (!done0 && guard < 20) begin
            tick();
            guard++;
        end
        chk(nm, {31'h0, done0}, 32'h1);
    endtask

    // Scoreboard: a run's result is popped when done rises.
    always @(negedge clk) begin
        if (rst_n && done0 && !done_prev) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_sig0", sig0, e.sig0);
                chk("sb_sig1", sig1, e.sig1);
                chk("sb_pass0", {31'h0, pass0}, {31'h0, e.pass0});
                chk("sb_pass1", {31'h0, pass1}, {31'h0, e.pass1});
                chk("sb_cnt0", {16'h0, cnt0}, e.cnt);
                chk("sb_cnt1", {16'h0, cnt1}, e.cnt);
                chk("sb_done1", {31'h0, done1}, 32'h1);
            end
        end
        done_prev <= rst_n & done0;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{16'd1, 32'h1, 32'h0, 32'h1,        32'h1, 32'hFB3EE248, 1'b1, 1'b0, 16'd1};
        tbl[1] = '{16'd2, 32'h1, 32'h0, 32'h2,        32'h2, 32'hF2BCD927, 1'b1, 1'b0, 16'd2};
        tbl[2] = '{16'd1, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'hFB3EE249, 1'b0, 1'b0, 16'd1};
        tbl[3] = '{16'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 16'd0};
        tbl[4] = '{16'd0, 32'h0, 32'h0, 32'h0,        32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 16'd0};

        // Reset state
        #12;
        chk("rst_sig0", sig0, 32'h0);
        chk("rst_sig1", sig1, 32'hFFFFFFFF);
        chk("rst_cnt", {16'h0, cnt0}, 32'h0);
        chk("rst_flags", {28'h0, rdy1, busy1, done1, pass1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 5; i++) begin
            clear_pulse();
            start_run(tbl[i].nv, tbl[i].es);
            if (tbl[i].nv == 16'd0) begin
                chk("zero_done", {31'h0, done0}, 32'h1);
                in_valid = 1'b1;
                tick();
                chk("zero_no_ready", {30'h0, rdy0, rdy1}, 32'h0);
                in_valid = 1'b0;
            end else begin
                beat(tbl[i].d0);
                if (tbl[i].nv > 16'd1) beat(tbl[i].d1);
                wait_done("tbl_done");
            end
            chk("tbl_sig0", sig0, tbl[i].e_sig0);
            chk("tbl_sig1", sig1, tbl[i].e_sig1);
            chk("tbl_pass0", {31'h0, pass0}, {31'h0, tbl[i].e_pass0});
            chk("tbl_pass1", {31'h0, pass1}, {31'h0, tbl[i].e_pass1});
            chk("tbl_cnt", {16'h0, cnt0}, {16'h0, tbl[i].e_cnt});
            chk("tbl_busy", {31'h0, busy0}, 32'h0);
        end

        // 1000 vectors with randomly gapped valid
        begin
            int cyc;
            clear_pulse();
            start_run(16'd1000, $urandom);
            cyc = 0;
            while (mcnt < 1000 && cyc < 8000) begin
                in_valid = ($urandom_range(0, 1) == 1);
                in_data  = $urandom;
                if (in_valid && rdy0) begin
                    m0 = ref_step(m0, in_data);
                    m1 = ref_step(m1, in_data);
                    mcnt++;
                    if (mcnt == 1000) begin
                        push_exp();
                        mrun = 1'b0;
                    end
                end
                tick();
                cyc++;
                if (mcnt == 500 && in_valid) chk("rand_mid_cnt", {16'h0, cnt1}, 32'd500);
            end
            in_valid = 1'b1;
            chk("rand_complete", mcnt, 32'd1000);
            chk("rand_ready_drop", {30'h0, rdy0, rdy1}, 32'h0);
            chk("rand_done", {31'h0, done0}, 32'h1);
            chk("rand_sig1", sig1, m1);
            tick();
            in_valid = 1'b0;
            chk("rand_hold_cnt", {16'h0, cnt0}, 32'd1000);
        end

        // clear mid-run after 3 beats
        clear_pulse();
        start_run(16'd10, 32'h0);
        for (int k = 0; k < 3; k++) beat($urandom);
        clear_pulse();
        chk("clr_flags", {29'h0, rdy0, busy0, done0}, 32'h0);
        chk("clr_pass", {31'h0, pass1}, 32'h0);
        chk("clr_sig0_hold", sig0, m0);
        chk("clr_sig1_hold", sig1, m1);
        chk("clr_cnt_hold", {16'h0, cnt0}, 32'd3);

        // start during RUN is ignored; new start reloads SEED
        start_run(16'd4, 32'h0);
        beat(32'hA5A5A5A5);
        beat(32'h0000FFFF);
        start_run(16'd1, 32'hDEADBEEF);
        chk("ign_busy", {31'h0, busy0}, 32'h1);
        chk("ign_cnt", {16'h0, cnt0}, 32'd2);
        beat(32'h12345678);
        beat(32'h80000001);
        chk("ign_done", {31'h0, done0}, 32'h1);
        chk("ign_sig1", sig1, m1);

        // rst_n low mid-run after 3 beats
        clear_pulse();
        start_run(16'd10, 32'h0);
        for (int k = 0; k < 3; k++) beat($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        mrun = 1'b0;
        chk("arst_sig0", sig0, 32'h0);
        chk("arst_sig1", sig1, 32'hFFFFFFFF);
        chk("arst_cnt", {16'h0, cnt1}, 32'h0);
        chk("arst_flags", {28'h0, rdy0, busy0, done0, pass0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_run(16'd2, 32'h0);
        beat(32'h00000001);
        beat(32'h00000000);
        chk("post_rst_sig0", sig0, 32'h2);
        chk("post_rst_pass0", {31'h0, pass0}, 32'h0);

        tick();
        tick();
        chk("sb_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
